// File: rtl/mips_pkg.sv
// Shared types and widths for the load/store unit.
// Holds the op/state enums and the request and writeback register layouts.
// No logic; imported by lsu_ctrl.
package mips_pkg;

  localparam int DW  = 16;  // data word width
  localparam int AW  = 5;   // memory word-address width (32 words)
  localparam int EAW = 16;  // effective-address width from execute
  localparam int RAW = 3;   // register-file address width

  typedef enum logic {
    LSU_LOAD  = 1'b0,
    LSU_STORE = 1'b1
  } lsu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2,
    S_WB    = 2'd3
  } lsu_state_e;

  typedef struct packed {
    lsu_op_e        op;
    logic [AW-1:0]  adr;
    logic [DW-1:0]  data;
    logic [RAW-1:0] rd;
  } lsu_req_t;

  typedef struct packed {
    logic           ena;
    logic [RAW-1:0] adr;
    logic [DW-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/lsu_ctrl.sv
// Load/store initiator between execute and a 32x16 combinational-read data memory.
// Latency: store writes on the 2nd edge after the accept cycle; load result valid 2 cycles after accept.
// Backpressure: one op in flight, ex_ready_o high only in IDLE; WB holds until wb_ready_i.
// Optional LSU_ADDR_CHECK_EN: out-of-range addresses are dropped and raise sticky err_o.
module lsu_ctrl
  import mips_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst,
  input  logic           ex_valid_i,
  output logic           ex_ready_o,
  input  logic           ex_op_i,
  input  logic [EAW-1:0] ex_addr_i,
  input  logic [DW-1:0]  ex_data_i,
  input  logic [RAW-1:0] ex_rd_i,
  output logic           mem_wr_ena_o,
  output logic [AW-1:0]  mem_wr_adr_o,
  output logic [DW-1:0]  mem_wr_data_o,
  output logic [AW-1:0]  mem_rd_adr_o,
  input  logic [DW-1:0]  mem_rd_data_i,
  output logic           wb_valid_o,
  input  logic           wb_ready_i,
  output logic [RAW-1:0] wb_adr_o,
  output logic [DW-1:0]  wb_data_o,
  output logic           err_o
);

  lsu_state_e     state_q, state_d;
  lsu_req_t       req_q;
  wb_req_t        wb_q;
  logic [AW-1:0]  rd_adr_q;
  logic           accept;
  logic           addr_bad;
  logic           take;

`ifdef LSU_ADDR_CHECK_EN
  logic           err_q;
  assign addr_bad = |ex_addr_i[EAW-1:AW];
  assign err_o    = err_q;
`else
  logic           unused_addr_hi;
  assign unused_addr_hi = ^ex_addr_i[EAW-1:AW];
  assign addr_bad = 1'b0;
  assign err_o    = 1'b0;
`endif

  assign ex_ready_o = (state_q == S_IDLE);
  assign accept     = ex_valid_i & ex_ready_o;
  // A dropped (out-of-range) op never touches the request registers.
  assign take       = accept & ~addr_bad;

  // Next-state selection; a dropped op simply leaves the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = (lsu_op_e'(ex_op_i) == LSU_STORE) ? S_STORE : S_LOAD;
      S_STORE: state_d = S_IDLE;
      S_LOAD:  state_d = S_WB;
      S_WB:    if (wb_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Capture the decoded request on a valid handshake.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else if (take) begin
      req_q.op   <= lsu_op_e'(ex_op_i);
      req_q.adr  <= ex_addr_i[AW-1:0];
      req_q.data <= ex_data_i;
      req_q.rd   <= ex_rd_i;
    end
  end

  // Read address only moves for loads, so it holds its last value otherwise.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) rd_adr_q <= '0;
    else if (take && lsu_op_e'(ex_op_i) == LSU_LOAD) rd_adr_q <= ex_addr_i[AW-1:0];
  end

  // Writeback register: filled at the end of LOAD, released on the wb handshake.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else if (state_q == S_LOAD) begin
      wb_q.ena  <= 1'b1;
      wb_q.adr  <= req_q.rd;
      wb_q.data <= mem_rd_data_i;
    end else if (state_q == S_WB && wb_ready_i) begin
      wb_q.ena  <= 1'b0;
    end
  end

`ifdef LSU_ADDR_CHECK_EN
  // Sticky range error, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (accept && addr_bad) err_q <= 1'b1;
  end
`endif

  assign mem_wr_ena_o  = (state_q == S_STORE);
  assign mem_wr_adr_o  = req_q.adr;
  assign mem_wr_data_o = req_q.data;
  assign mem_rd_adr_o  = rd_adr_q;
  assign wb_valid_o    = wb_q.ena;
  assign wb_adr_o      = wb_q.adr;
  assign wb_data_o     = wb_q.data;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural 32x16 memory attached.
// Expected values are hand-computed constants.
// Build with or without LSU_ADDR_CHECK_EN; the range check adapts.
module tb_lsu_ctrl;
  import mips_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst;
  logic           ex_valid_i;
  logic           ex_ready_o;
  logic           ex_op_i;
  logic [EAW-1:0] ex_addr_i;
  logic [DW-1:0]  ex_data_i;
  logic [RAW-1:0] ex_rd_i;
  logic           mem_wr_ena_o;
  logic [AW-1:0]  mem_wr_adr_o;
  logic [DW-1:0]  mem_wr_data_o;
  logic [AW-1:0]  mem_rd_adr_o;
  logic [DW-1:0]  mem_rd_data_i;
  logic           wb_valid_o;
  logic           wb_ready_i;
  logic [RAW-1:0] wb_adr_o;
  logic [DW-1:0]  wb_data_o;
  logic           err_o;

  logic [DW-1:0]  mem [32];
  int             n_chk = 0;
  int             n_err = 0;

  lsu_ctrl dut (
    .clk_i         (clk_i),
    .rst           (rst),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_op_i       (ex_op_i),
    .ex_addr_i     (ex_addr_i),
    .ex_data_i     (ex_data_i),
    .ex_rd_i       (ex_rd_i),
    .mem_wr_ena_o  (mem_wr_ena_o),
    .mem_wr_adr_o  (mem_wr_adr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_adr_o  (mem_rd_adr_o),
    .mem_rd_data_i (mem_rd_data_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_adr_o      (wb_adr_o),
    .wb_data_o     (wb_data_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Data memory: synchronous write, combinational read.
  always @(posedge clk_i) if (mem_wr_ena_o) mem[mem_wr_adr_o] <= mem_wr_data_o;
  assign mem_rd_data_i = mem[mem_rd_adr_o];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic op, input logic [EAW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [RAW-1:0] rd);
    ex_valid_i = 1'b1;
    ex_op_i    = op;
    ex_addr_i  = adr;
    ex_data_i  = dat;
    ex_rd_i    = rd;
    cyc();
    ex_valid_i = 1'b0;
  endtask

  logic [RAW-1:0] hold_adr;
  logic [DW-1:0]  hold_dat;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst = 1'b1; ex_valid_i = 1'b0; ex_op_i = 1'b0; ex_addr_i = '0;
    ex_data_i = '0; ex_rd_i = '0; wb_ready_i = 1'b0;
    cyc(); cyc();

    // Reset state
    chk("rst_ready",  ex_ready_o,   1);
    chk("rst_wr_ena", mem_wr_ena_o, 0);
    chk("rst_wb_vld", wb_valid_o,   0);
    chk("rst_wb_adr", wb_adr_o,     0);
    chk("rst_wb_dat", wb_data_o,    0);
    chk("rst_rd_adr", mem_rd_adr_o, 0);
    chk("rst_err",    err_o,        0);
    rst = 1'b0;
    cyc();

    // Store A5A5 -> 5: one write cycle with execute stalled
    chk("st_ready_idle", ex_ready_o, 1);
    issue(1'b1, 16'd5, 16'hA5A5, 3'd0);
    chk("st_wr_ena", mem_wr_ena_o,  1);
    chk("st_wr_adr", mem_wr_adr_o,  5);
    chk("st_wr_dat", mem_wr_data_o, 16'hA5A5);
    chk("st_ready",  ex_ready_o,    0);
    cyc();
    chk("st_wr_off", mem_wr_ena_o, 0);
    chk("st_back",   ex_ready_o,   1);
    chk("st_mem5",   mem[5],       16'hA5A5);

    // Load 1234 from 7 into r3, with 4 cycles of writeback backpressure
    issue(1'b1, 16'd7, 16'h1234, 3'd0);
    cyc();
    issue(1'b0, 16'd7, 16'h0000, 3'd3);
    chk("ld_wb_early", wb_valid_o,   0);
    chk("ld_rd_adr",   mem_rd_adr_o, 7);
    chk("ld_ready",    ex_ready_o,   0);
    cyc();
    chk("ld_wb_vld", wb_valid_o, 1);
    chk("ld_wb_adr", wb_adr_o,   3);
    chk("ld_wb_dat", wb_data_o,  16'h1234);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_vld",   wb_valid_o, 1);
      chk("bp_adr",   wb_adr_o,   3);
      chk("bp_dat",   wb_data_o,  16'h1234);
      chk("bp_ready", ex_ready_o, 0);
    end
    wb_ready_i = 1'b1;
    cyc();
    chk("bp_rel_vld",   wb_valid_o,   0);
    chk("bp_rel_ready", ex_ready_o,   1);
    chk("rd_adr_hold",  mem_rd_adr_o, 7);

    // Store BEEF -> 9 then load 9 into r2 back-to-back; ready already high at WB
    issue(1'b1, 16'd9, 16'hBEEF, 3'd0);
    cyc();
    issue(1'b0, 16'd9, 16'h0000, 3'd2);
    cyc();
    chk("raw_vld", wb_valid_o, 1);
    chk("raw_adr", wb_adr_o,   2);
    chk("raw_dat", wb_data_o,  16'hBEEF);
    cyc();
    chk("raw_done_vld",   wb_valid_o, 0);
    chk("raw_done_ready", ex_ready_o, 1);
    wb_ready_i = 1'b0;

    // Reset in the middle of a load: nothing comes back afterwards
    issue(1'b0, 16'd5, 16'h0000, 3'd4);
    chk("mid_in_load", ex_ready_o, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready",  ex_ready_o,   1);
    chk("mid_rst_wb_vld", wb_valid_o,   0);
    chk("mid_rst_wr_ena", mem_wr_ena_o, 0);
    cyc();
    rst = 1'b0;
    wb_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_wb_vld", wb_valid_o, 0);
      chk("post_rst_ready",  ex_ready_o, 1);
    end
    wb_ready_i = 1'b0;

    // Out-of-range store address 0x0025
    issue(1'b1, 16'h0025, 16'h5A5A, 3'd0);
`ifdef LSU_ADDR_CHECK_EN
    chk("rng_no_wr",  mem_wr_ena_o, 0);
    chk("rng_err",    err_o,        1);
    chk("rng_ready",  ex_ready_o,   1);
    cyc(); cyc();
    chk("rng_sticky", err_o,        1);
    chk("rng_mem5",   mem[5],       16'hA5A5);
    rst = 1'b1;
    #1;
    chk("rng_rst_clr", err_o, 0);
    cyc();
    rst = 1'b0;
`else
    chk("rng_wr_ena", mem_wr_ena_o,  1);
    chk("rng_wr_adr", mem_wr_adr_o,  5);
    chk("rng_wr_dat", mem_wr_data_o, 16'h5A5A);
    chk("rng_err",    err_o,         0);
    cyc();
    chk("rng_mem5",   mem[5],        16'h5A5A);
    chk("rng_err2",   err_o,         0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
